// File: rtl/spart_ctrl.sv
// -----------------------------------------------------------------------------
// spart_ctrl
//   Bus-side controller for one SPART instance. After reset it programs the
//   baud divisor (low byte, then high byte) and then services the link. In
//   the service loop it reads received bytes into a one-entry holding register
//   and shares the transmitter between two clients in round-robin order.
//
// Ports
//   clk        system clock; all state changes on the rising edge
//   rst        asynchronous, active-low reset
//   tx_req0    client 0 transmit request, held until tx_ack0
//   tx_data0   client 0 byte, stable from request until ack
//   tx_ack0    one-cycle pulse: tx_data0 written to the SPART
//   tx_req1    client 1 transmit request
//   tx_data1   client 1 byte
//   tx_ack1    one-cycle pulse: tx_data1 written to the SPART
//   rx_valid   rx_data holds an unconsumed byte
//   rx_data    received byte
//   rx_ready   consumer accepts rx_data when rx_valid & rx_ready
//   cfg_done   high once the divisor is written, until the next reset
//   rda        SPART receive-data-available
//   tbr        SPART transmit-buffer-ready
//   iorw       1 = read from the SPART, 0 = write
//   ioaddr     00 TX/RX buffer, 01 status, 10 divisor low, 11 divisor high
//   databus    bidirectional SPART data bus, driven only while iorw = 0
// -----------------------------------------------------------------------------
module spart_ctrl #(
    parameter logic [15:0] DIVISOR = 16'd325
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       tx_req0,
    input  logic [7:0] tx_data0,
    output logic       tx_ack0,
    input  logic       tx_req1,
    input  logic [7:0] tx_data1,
    output logic       tx_ack1,
    output logic       rx_valid,
    output logic [7:0] rx_data,
    input  logic       rx_ready,
    output logic       cfg_done,
    input  logic       rda,
    input  logic       tbr,
    output logic       iorw,
    output logic [1:0] ioaddr,
    inout  wire  [7:0] databus
);

    typedef enum logic [2:0] {
        CFG_LO,
        CFG_HI,
        IDLE,
        RX_RD,
        RX_SET,
        TX_WR,
        TX_SET
    } state_t;

    localparam logic [1:0] ADDR_BUF    = 2'b00;
    localparam logic [1:0] ADDR_STATUS = 2'b01;
    localparam logic [1:0] ADDR_DB_LO  = 2'b10;
    localparam logic [1:0] ADDR_DB_HI  = 2'b11;

    state_t     state;
    state_t     next_state;
    logic       rr_ptr;     // client that wins the next two-way contest
    logic       gnt;        // client granted for the upcoming TX_WR
    logic       win;        // arbitration result evaluated in IDLE
    logic       drive;      // enable for the databus output driver
    logic [7:0] dout;

    // Single requester wins outright; on a tie rr_ptr decides.
    assign win = (tx_req0 && tx_req1) ? rr_ptr : tx_req1;

    assign databus = drive ? dout : 8'hzz;

    // -------------------------------------------------------------------------
    // State register
    // -------------------------------------------------------------------------
    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples pre-edge values regardless of block ordering in simulation.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= CFG_LO;
        end else begin
            state <= next_state;
        end
    end

    // -------------------------------------------------------------------------
    // Next-state logic
    // -------------------------------------------------------------------------
    // NOTE: every combinational output gets a default before the case so no
    // path leaves it unassigned, which would infer a latch.
    always_comb begin
        next_state = state;
        case (state)
            CFG_LO: next_state = CFG_HI;
            CFG_HI: next_state = IDLE;
            IDLE: begin
                // Receive has priority so the SPART RX buffer drains first.
                if (rda && !rx_valid) begin
                    next_state = RX_RD;
                end else if (tbr && (tx_req0 || tx_req1)) begin
                    next_state = TX_WR;
                end
            end
            RX_RD:   next_state = RX_SET;
            RX_SET:  next_state = IDLE;
            TX_WR:   next_state = TX_SET;
            TX_SET:  next_state = IDLE;
            default: next_state = CFG_LO;
        endcase
    end

    // -------------------------------------------------------------------------
    // Output logic
    // -------------------------------------------------------------------------
    // The reset state is CFG_LO, whose decode would drive the bus; qualifying
    // with rst keeps the bus idle for the whole time reset is asserted.
    always_comb begin
        iorw    = 1'b1;
        ioaddr  = ADDR_STATUS;
        drive   = 1'b0;
        dout    = 8'h00;
        tx_ack0 = 1'b0;
        tx_ack1 = 1'b0;
        if (rst) begin
            case (state)
                CFG_LO: begin
                    iorw   = 1'b0;
                    ioaddr = ADDR_DB_LO;
                    drive  = 1'b1;
                    dout   = DIVISOR[7:0];
                end
                CFG_HI: begin
                    iorw   = 1'b0;
                    ioaddr = ADDR_DB_HI;
                    drive  = 1'b1;
                    dout   = DIVISOR[15:8];
                end
                RX_RD: begin
                    ioaddr = ADDR_BUF;
                end
                TX_WR: begin
                    iorw    = 1'b0;
                    ioaddr  = ADDR_BUF;
                    drive   = 1'b1;
                    dout    = gnt ? tx_data1 : tx_data0;
                    tx_ack0 = !gnt;
                    tx_ack1 = gnt;
                end
                default: ;
            endcase
        end
    end

    // -------------------------------------------------------------------------
    // Datapath: grant, round-robin pointer, RX holding register, cfg flag
    // -------------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            gnt      <= 1'b0;
            rr_ptr   <= 1'b0;
            rx_valid <= 1'b0;
            rx_data  <= 8'h00;
            cfg_done <= 1'b0;
        end else begin
            if (state == IDLE && next_state == TX_WR) begin
                gnt <= win;
            end
            // After any grant the other client is favoured next time.
            if (state == TX_WR) begin
                rr_ptr <= ~gnt;
            end
            if (state == CFG_HI) begin
                cfg_done <= 1'b1;
            end
            // RX_RD is entered only with rx_valid low, so capture and
            // consumer accept never fall in the same cycle.
            if (state == RX_RD) begin
                rx_data  <= databus;
                rx_valid <= 1'b1;
            end else if (rx_valid && rx_ready) begin
                rx_valid <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_spart_ctrl.sv
// -----------------------------------------------------------------------------
// tb_spart_ctrl
//   Scoreboard bench for spart_ctrl. Stimulus pushes the expected SPART bus
//   accesses and consumer handshakes into a queue; a monitor on the falling
//   edge pops and compares each one as the DUT presents it. A small SPART
//   model drives databus during buffer reads.
// -----------------------------------------------------------------------------
module tb_spart_ctrl;

    typedef enum logic [2:0] {EV_CFG_LO, EV_CFG_HI, EV_TX0, EV_TX1, EV_RD, EV_RX} ev_kind_t;
    typedef struct {
        ev_kind_t   kind;
        logic [7:0] data;
    } ev_t;

    logic       clk;
    logic       rst;
    logic       tx_req0;
    logic [7:0] tx_data0;
    logic       tx_ack0;
    logic       tx_req1;
    logic [7:0] tx_data1;
    logic       tx_ack1;
    logic       rx_valid;
    logic [7:0] rx_data;
    logic       rx_ready;
    logic       cfg_done;
    logic       rda;
    logic       tbr;
    logic       iorw;
    logic [1:0] ioaddr;
    wire  [7:0] databus;

    logic [7:0] spart_rx;
    logic       spart_drv;

    int  tests;
    int  fails;
    ev_t exp_q[$];
    bit  prev_acc;

    spart_ctrl dut (
        .clk      (clk),
        .rst      (rst),
        .tx_req0  (tx_req0),
        .tx_data0 (tx_data0),
        .tx_ack0  (tx_ack0),
        .tx_req1  (tx_req1),
        .tx_data1 (tx_data1),
        .tx_ack1  (tx_ack1),
        .rx_valid (rx_valid),
        .rx_data  (rx_data),
        .rx_ready (rx_ready),
        .cfg_done (cfg_done),
        .rda      (rda),
        .tbr      (tbr),
        .iorw     (iorw),
        .ioaddr   (ioaddr),
        .databus  (databus)
    );

    // SPART model: presents its receive byte only during a buffer read.
    assign spart_drv = rst && iorw && (ioaddr == 2'b00);
    assign databus   = spart_drv ? spart_rx : 8'hzz;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [15:0] got, input logic [15:0] want);
        tests++;
        if (got !== want) begin
            fails++;
            $display("FAIL %s: got %0h, expected %0h", name, got, want);
        end
    endtask

    task automatic push(input ev_kind_t k, input logic [7:0] d);
        ev_t e;
        e.kind = k;
        e.data = d;
        exp_q.push_back(e);
    endtask

    task automatic observe(input ev_kind_t k, input logic [7:0] d);
        ev_t e;
        tests++;
        if (exp_q.size() == 0) begin
            fails++;
            $display("FAIL unexpected_event: got %s/%02h, expected none", k.name(), d);
        end else begin
            e = exp_q.pop_front();
            if (e.kind != k || e.data !== d) begin
                fails++;
                $display("FAIL event_order: got %s/%02h, expected %s/%02h",
                         k.name(), d, e.kind.name(), e.data);
            end
        end
    endtask

    // Monitor: samples on the falling edge, away from the active edge.
    initial begin
        prev_acc = 1'b0;
        forever begin
            @(negedge clk);
            if (rst) begin
                if ((tx_ack0 || tx_ack1) && !(!iorw && ioaddr == 2'b00)) begin
                    tests++;
                    fails++;
                    $display("FAIL stray_ack: got ack0=%0b ack1=%0b outside TX write", tx_ack0, tx_ack1);
                end
                if (!iorw) begin
                    case (ioaddr)
                        2'b10: observe(EV_CFG_LO, databus);
                        2'b11: observe(EV_CFG_HI, databus);
                        2'b00: begin
                            check("ack_onehot", {14'd0, tx_ack1, tx_ack0}, tx_ack1 ? 16'd2 : 16'd1);
                            observe(tx_ack1 ? EV_TX1 : EV_TX0, databus);
                        end
                        default: begin
                            tests++;
                            fails++;
                            $display("FAIL status_write: got write to ioaddr %0d, expected none", ioaddr);
                        end
                    endcase
                end else if (ioaddr == 2'b00) begin
                    observe(EV_RD, databus);
                end
                if (rx_valid && rx_ready) observe(EV_RX, rx_data);
                if (ioaddr == 2'b00) begin
                    check("access_spacing", {15'd0, prev_acc}, 16'd0);
                end
                prev_acc = (ioaddr == 2'b00);
            end else begin
                prev_acc = 1'b0;
            end
        end
    end

    task automatic cyc(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic wait_ack(input bit c);
        int k;
        k = 0;
        while (k < 50) begin
            @(negedge clk);
            if (c ? tx_ack1 : tx_ack0) break;
            k++;
        end
        if (k == 50) begin
            tests++;
            fails++;
            $display("FAIL ack_timeout: got no tx_ack%0d, expected one within 50 cycles", c);
        end
        @(posedge clk);
        #1;
    endtask

    task automatic wait_rx();
        int k;
        k = 0;
        while (k < 50) begin
            @(negedge clk);
            if (rx_valid) break;
            k++;
        end
        if (k == 50) begin
            tests++;
            fails++;
            $display("FAIL rx_timeout: got rx_valid=0, expected 1 within 50 cycles");
        end
        @(posedge clk);
        #1;
    endtask

    initial begin
        int n0;
        int n1;
        int k;
        tests    = 0;
        fails    = 0;
        rst      = 1'b0;
        tx_req0  = 1'b0;
        tx_data0 = 8'h00;
        tx_req1  = 1'b0;
        tx_data1 = 8'h00;
        rx_ready = 1'b0;
        rda      = 1'b0;
        tbr      = 1'b1;
        spart_rx = 8'h00;

        // Reset values.
        cyc(2);
        check("rst_iorw",     {15'd0, iorw},     16'd1);
        check("rst_ioaddr",   {14'd0, ioaddr},   16'd1);
        check("rst_ack0",     {15'd0, tx_ack0},  16'd0);
        check("rst_ack1",     {15'd0, tx_ack1},  16'd0);
        check("rst_rx_valid", {15'd0, rx_valid}, 16'd0);
        check("rst_rx_data",  {8'd0, rx_data},   16'd0);
        check("rst_cfg_done", {15'd0, cfg_done}, 16'd0);

        // 1. Divisor 325 = 0x0145 written low byte then high byte.
        push(EV_CFG_LO, 8'h45);
        push(EV_CFG_HI, 8'h01);
        rst = 1'b1;
        cyc(3);
        check("cfg_done_set", {15'd0, cfg_done}, 16'd1);
        check("idle_iorw",    {15'd0, iorw},     16'd1);
        check("idle_ioaddr",  {14'd0, ioaddr},   16'd1);

        // 2. Single requests from each client; client 1 last leaves rr_ptr=0.
        tx_data0 = 8'hA5;
        tx_req0  = 1'b1;
        push(EV_TX0, 8'hA5);
        wait_ack(1'b0);
        tx_req0 = 1'b0;
        cyc(1);
        tx_data1 = 8'h5A;
        tx_req1  = 1'b1;
        push(EV_TX1, 8'h5A);
        wait_ack(1'b1);
        tx_req1 = 1'b0;
        cyc(1);

        // 3. Both clients hold requests: grants alternate 0,1,0,1.
        push(EV_TX0, 8'hC0);
        push(EV_TX1, 8'hD0);
        push(EV_TX0, 8'hC1);
        push(EV_TX1, 8'hD1);
        n0 = 0;
        n1 = 0;
        k  = 0;
        tx_data0 = 8'hC0;
        tx_data1 = 8'hD0;
        tx_req0  = 1'b1;
        tx_req1  = 1'b1;
        while ((n0 < 2 || n1 < 2) && k < 60) begin
            @(negedge clk);
            if (tx_ack0) n0++;
            if (tx_ack1) n1++;
            @(posedge clk);
            #1;
            tx_data0 = 8'(8'hC0 + n0);
            tx_data1 = 8'(8'hD0 + n1);
            tx_req0  = (n0 < 2);
            tx_req1  = (n1 < 2);
            k++;
        end
        if (n0 < 2 || n1 < 2) begin
            tests++;
            fails++;
            $display("FAIL rr_timeout: got %0d/%0d acks, expected 2/2", n0, n1);
        end
        tx_req0 = 1'b0;
        tx_req1 = 1'b0;
        cyc(1);

        // 4. Read, hold rda while the byte is unconsumed, accept, re-read.
        spart_rx = 8'h3C;
        rda      = 1'b1;
        push(EV_RD, 8'h3C);
        wait_rx();
        cyc(5);
        check("rx_hold_valid", {15'd0, rx_valid}, 16'd1);
        check("rx_hold_data",  {8'd0, rx_data},   16'h3C);
        spart_rx = 8'h7E;
        push(EV_RX, 8'h3C);
        push(EV_RD, 8'h7E);
        rx_ready = 1'b1;
        cyc(1);
        rx_ready = 1'b0;
        wait_rx();
        rda = 1'b0;
        push(EV_RX, 8'h7E);
        rx_ready = 1'b1;
        cyc(1);
        rx_ready = 1'b0;

        // 5. rda and a client-1 request together: read first, then write.
        spart_rx = 8'h99;
        rda      = 1'b1;
        tx_data1 = 8'h77;
        tx_req1  = 1'b1;
        push(EV_RD, 8'h99);
        push(EV_TX1, 8'h77);
        wait_rx();
        rda = 1'b0;
        wait_ack(1'b1);
        tx_req1 = 1'b0;
        push(EV_RX, 8'h99);
        rx_ready = 1'b1;
        cyc(1);
        rx_ready = 1'b0;

        // 6. Leave a byte held, then reset in the middle of a TX_WR.
        spart_rx = 8'h5C;
        rda      = 1'b1;
        push(EV_RD, 8'h5C);
        wait_rx();
        rda      = 1'b0;
        tx_data1 = 8'hEE;
        tx_req1  = 1'b1;
        cyc(1);
        rst = 1'b0;
        #2;
        check("abort_iorw",     {15'd0, iorw},     16'd1);
        check("abort_ioaddr",   {14'd0, ioaddr},   16'd1);
        check("abort_ack1",     {15'd0, tx_ack1},  16'd0);
        check("abort_rx_valid", {15'd0, rx_valid}, 16'd0);
        check("abort_rx_data",  {8'd0, rx_data},   16'd0);
        check("abort_cfg_done", {15'd0, cfg_done}, 16'd0);
        // The still-pending request waits for the divisor rewrite.
        push(EV_CFG_LO, 8'h45);
        push(EV_CFG_HI, 8'h01);
        push(EV_TX1, 8'hEE);
        cyc(1);
        rst = 1'b1;
        wait_ack(1'b1);
        tx_req1 = 1'b0;
        check("recfg_done", {15'd0, cfg_done}, 16'd1);
        cyc(3);

        check("scoreboard_drained", 16'(exp_q.size()), 16'd0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
